// File: rtl/rll_pkg.sv
// Shared types and helpers for the keyed RLL stage and the scripts that generate its keys.
package rll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    ARMED
  } rll_state_e;

  localparam int MAX_KEY_W = 64;

  // The key that makes the gate bank transparent.
  function automatic logic [MAX_KEY_W-1:0] correct_key(input logic [MAX_KEY_W-1:0] pol,
                                                       input logic [MAX_KEY_W-1:0] inv);
    return pol ^ inv;
  endfunction

endpackage

// File: rtl/rll_keyed_stage_if.sv
// Key-provisioning and data-stream signals of the keyed stage, bundled with both views.
interface rll_keyed_stage_if #(
  parameter int DATA_W    = 32,
  parameter int KEY_CHUNK = 8
);

  logic                 key_valid;
  logic                 key_ready;
  logic [KEY_CHUNK-1:0] key_data;
  logic                 key_clear;
  logic                 armed;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;

  modport master (
    output key_valid, key_data, key_clear, in_valid, in_data, out_ready,
    input  key_ready, armed, in_ready, out_valid, out_data
  );

  modport slave (
    input  key_valid, key_data, key_clear, in_valid, in_data, out_ready,
    output key_ready, armed, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/rll_key_loader.sv
// Serial key loader: takes KEY_W/KEY_CHUNK chunked beats into the key register and
// reports when the full key is present.
module rll_key_loader
  import rll_pkg::*;
#(
  parameter int KEY_W     = 32,
  parameter int KEY_CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [KEY_CHUNK-1:0] key_data,
  input  logic                 key_clear,
  output logic                 key_ready,
  output logic [KEY_W-1:0]     key,
  output logic                 armed
);

  localparam int NBEATS = KEY_W / KEY_CHUNK;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  rll_state_e       state;
  rll_state_e       next_state;
  logic [CNT_W-1:0] beat;
  logic             accept;
  logic             last_beat;

  // Ready is held low during reset so no beat can be taken before release.
  assign key_ready = rst_n && (state != ARMED);
  assign accept    = key_valid && (state != ARMED);
  assign last_beat = (beat == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = last_beat ? ARMED : LOADING;
      LOADING: if (accept && last_beat) next_state = ARMED;
      ARMED:   next_state = ARMED;
      default: next_state = IDLE;
    endcase
    if (key_clear) begin
      next_state = IDLE;
    end
  end

  // armed decodes the next state so it rises together with the ARMED state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key   <= '0;
      beat  <= '0;
      armed <= 1'b0;
    end else begin
      armed <= (next_state == ARMED);
      if (key_clear) begin
        key  <= '0;
        beat <= '0;
      end else if (accept) begin
        for (int b = 0; b < NBEATS; b++) begin
          if (beat == CNT_W'(b)) begin
            key[b*KEY_CHUNK +: KEY_CHUNK] <= key_data;
          end
        end
        beat <= last_beat ? '0 : beat + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rll_keyed_stage.sv
// Keyed RLL stage: per-bit XOR/XNOR/NOT key gates on the low KEY_W data bits followed by
// one registered pipeline stage with valid/ready flow control.
module rll_keyed_stage #(
  parameter int               DATA_W    = 32,
  parameter int               KEY_W     = 32,
  parameter int               KEY_CHUNK = 8,
  parameter logic [KEY_W-1:0] KEY_POL   = KEY_W'(32'hA5A5_0F0F),
  parameter logic [KEY_W-1:0] KEY_INV   = KEY_W'(32'h0000_FFFF)
) (
  input logic               clk,
  input logic               rst_n,
  rll_keyed_stage_if.slave  bus
);

  logic [KEY_W-1:0]  key;
  logic              armed;
  logic [DATA_W-1:0] gated;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              in_ready;

  rll_key_loader #(
    .KEY_W     (KEY_W),
    .KEY_CHUNK (KEY_CHUNK)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (bus.key_valid),
    .key_data  (bus.key_data),
    .key_clear (bus.key_clear),
    .key_ready (bus.key_ready),
    .key       (key),
    .armed     (armed)
  );

  // XOR gate, optional XNOR polarity and optional trailing inverter fold into one XOR chain.
  for (genvar i = 0; i < DATA_W; i++) begin : g_gate
    if (i < KEY_W) begin : g_keyed
      assign gated[i] = bus.in_data[i] ^ key[i] ^ KEY_POL[i] ^ KEY_INV[i];
    end else begin : g_pass
      assign gated[i] = bus.in_data[i];
    end
  end

  assign in_ready = armed && (!out_valid_q || bus.out_ready);

  // key_clear drops any held word; out_data keeps its stale value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (bus.key_clear) begin
      out_valid_q <= 1'b0;
    end else if (bus.in_valid && in_ready) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gated;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.armed     = armed;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_rll_keyed_stage.sv
// Scoreboard bench for rll_keyed_stage: default 32-bit instance plus a 48/16/16 instance.
module tb_rll_keyed_stage;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_q[$];
  logic [47:0] exp_w_q[$];
  logic [31:0] mon_e;
  logic [47:0] mon_w_e;

  rll_keyed_stage_if #(.DATA_W(32), .KEY_CHUNK(8))  bus ();
  rll_keyed_stage_if #(.DATA_W(48), .KEY_CHUNK(16)) bus_w ();

  rll_keyed_stage #(
    .DATA_W(32), .KEY_W(32), .KEY_CHUNK(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rll_keyed_stage #(
    .DATA_W(48), .KEY_W(16), .KEY_CHUNK(16)
  ) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run still active at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitors: a word is consumed at the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", {32'h0, bus.out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("out_data", {32'h0, bus.out_data}, {32'h0, mon_e});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_w.out_valid && bus_w.out_ready) begin
      if (exp_w_q.size() == 0) begin
        checkOutput("unexpected_out_w", {16'h0, bus_w.out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_w_e = exp_w_q.pop_front();
        checkOutput("out_data_w", {16'h0, bus_w.out_data}, {16'h0, mon_w_e});
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] d, input logic [31:0] e);
    int c = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!bus.in_ready) begin
      checkOutput("in_ready_timeout", {63'h0, bus.in_ready}, 64'h1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
      #1;
    end
  endtask

  task automatic applyWideStimulus(input logic [47:0] d, input logic [47:0] e);
    int c = 0;
    bus_w.in_valid = 1'b1;
    bus_w.in_data  = d;
    @(negedge clk);
    while (!bus_w.in_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!bus_w.in_ready) begin
      checkOutput("in_ready_timeout_w", {63'h0, bus_w.in_ready}, 64'h1);
      bus_w.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_w_q.push_back(e);
      #1;
    end
  endtask

  task automatic loadBeat(input logic [7:0] b, input bit clr);
    bus.key_valid = 1'b1;
    bus.key_data  = b;
    bus.key_clear = clr;
    @(negedge clk);
    checkOutput("key_ready_on_beat", {63'h0, bus.key_ready}, 64'h1);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_clear = 1'b0;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.key_valid = 0; bus.key_data = '0; bus.key_clear = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
    bus_w.key_valid = 0; bus_w.key_data = '0; bus_w.key_clear = 0;
    bus_w.in_valid = 0; bus_w.in_data = '0; bus_w.out_ready = 1;

    #3;
    checkOutput("rst_key_ready", {63'h0, bus.key_ready}, 64'h0);
    checkOutput("rst_armed", {63'h0, bus.armed}, 64'h0);
    checkOutput("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    checkOutput("rst_out_data", {32'h0, bus.out_data}, 64'h0);
    checkOutput("rst_in_ready", {63'h0, bus.in_ready}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_key_ready", {63'h0, bus.key_ready}, 64'h1);
    checkOutput("rel_armed", {63'h0, bus.armed}, 64'h0);
    @(posedge clk);
    #1;

    // Data offered while unarmed must never be taken.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      checkOutput("idle_in_ready", {63'h0, bus.in_ready}, 64'h0);
      checkOutput("idle_out_valid", {63'h0, bus.out_valid}, 64'h0);
    end
    stepCycles(1);
    loadBeat(8'hF0, 1'b0);
    checkOutput("loading_in_ready", {63'h0, bus.in_ready}, 64'h0);
    loadBeat(8'hF0, 1'b0);
    loadBeat(8'hA5, 1'b0);
    checkOutput("pre_final_armed", {63'h0, bus.armed}, 64'h0);
    checkOutput("loading_out_valid", {63'h0, bus.out_valid}, 64'h0);
    bus.in_valid = 1'b0;
    loadBeat(8'hA5, 1'b0);
    checkOutput("armed_after_load", {63'h0, bus.armed}, 64'h1);
    checkOutput("armed_key_ready", {63'h0, bus.key_ready}, 64'h0);
    checkOutput("armed_in_ready", {63'h0, bus.in_ready}, 64'h1);

    // Correct key: transparent, back-to-back words.
    applyStimulus(32'h1234_5678, 32'h1234_5678);
    checkOutput("latency_valid", {63'h0, bus.out_valid}, 64'h1);
    checkOutput("latency_data", {32'h0, bus.out_data}, 64'h1234_5678);
    applyStimulus(32'hFFFF_0000, 32'hFFFF_0000);
    applyStimulus(32'h0F0F_A5A5, 32'h0F0F_A5A5);
    bus.in_valid = 1'b0;
    stepCycles(2);

    // Key beats while armed are ignored.
    bus.key_valid = 1'b1;
    bus.key_data  = 8'h00;
    @(negedge clk);
    checkOutput("armed_key_ignored", {63'h0, bus.key_ready}, 64'h0);
    stepCycles(2);
    bus.key_valid = 1'b0;
    applyStimulus(32'hABCD_0123, 32'hABCD_0123);
    bus.in_valid = 1'b0;
    stepCycles(2);

    // Backpressure holds the word and blocks input.
    bus.out_ready = 1'b0;
    applyStimulus(32'hCAFE_BABE, 32'hCAFE_BABE);
    bus.in_data = 32'h0BAD_F00D;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_out_valid", {63'h0, bus.out_valid}, 64'h1);
      checkOutput("bp_out_data", {32'h0, bus.out_data}, 64'hCAFE_BABE);
      checkOutput("bp_in_ready", {63'h0, bus.in_ready}, 64'h0);
    end
    stepCycles(1);
    bus.out_ready = 1'b1;
    applyStimulus(32'h0BAD_F00D, 32'h0BAD_F00D);
    bus.in_valid = 1'b0;
    stepCycles(2);

    // Wrong (all-zero) key.
    bus.key_clear = 1'b1;
    stepCycles(1);
    bus.key_clear = 1'b0;
    checkOutput("clear_armed", {63'h0, bus.armed}, 64'h0);
    checkOutput("clear_key_ready", {63'h0, bus.key_ready}, 64'h1);
    checkOutput("clear_in_ready", {63'h0, bus.in_ready}, 64'h0);
    repeat (4) loadBeat(8'h00, 1'b0);
    checkOutput("zero_key_armed", {63'h0, bus.armed}, 64'h1);
    applyStimulus(32'h0000_0000, 32'hA5A5_F0F0);
    applyStimulus(32'hFFFF_FFFF, 32'h5A5A_0F0F);
    applyStimulus(32'h1234_5678, 32'hB791_A688);
    bus.in_valid = 1'b0;
    stepCycles(2);

    // key_clear drops a held word.
    bus.out_ready = 1'b0;
    applyStimulus(32'h1111_1111, 32'hB4B4_E1E1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("held_data", {32'h0, bus.out_data}, 64'hB4B4_E1E1);
    stepCycles(1);
    bus.key_clear = 1'b1;
    stepCycles(1);
    bus.key_clear = 1'b0;
    exp_q.delete();
    checkOutput("drop_out_valid", {63'h0, bus.out_valid}, 64'h0);
    checkOutput("drop_armed", {63'h0, bus.armed}, 64'h0);
    checkOutput("drop_stale_data", {32'h0, bus.out_data}, 64'hB4B4_E1E1);
    bus.out_ready = 1'b1;

    // key_clear on the final beat wins; a fresh load then arms.
    loadBeat(8'hF0, 1'b0);
    loadBeat(8'hF0, 1'b0);
    loadBeat(8'hA5, 1'b0);
    loadBeat(8'hA5, 1'b1);
    checkOutput("clr_final_armed", {63'h0, bus.armed}, 64'h0);
    checkOutput("clr_final_key_ready", {63'h0, bus.key_ready}, 64'h1);
    repeat (2) begin
      @(negedge clk);
      checkOutput("clr_final_stays_unarmed", {63'h0, bus.armed}, 64'h0);
    end
    stepCycles(1);
    loadBeat(8'hF0, 1'b0);
    loadBeat(8'hF0, 1'b0);
    loadBeat(8'hA5, 1'b0);
    loadBeat(8'hA5, 1'b0);
    checkOutput("reload_armed", {63'h0, bus.armed}, 64'h1);
    applyStimulus(32'h89AB_CDEF, 32'h89AB_CDEF);
    bus.in_valid = 1'b0;
    stepCycles(2);
    checkOutput("drain", 64'(exp_q.size()), 64'h0);

    // Wide instance: single-beat key, upper bits pass through.
    bus_w.key_valid = 1'b1;
    bus_w.key_data  = 16'hF0F0;
    stepCycles(1);
    bus_w.key_valid = 1'b0;
    checkOutput("w_single_beat_armed", {63'h0, bus_w.armed}, 64'h1);
    applyWideStimulus(48'hFFFF_0000_1234, 48'hFFFF_0000_1234);
    bus_w.in_valid = 1'b0;
    stepCycles(2);
    bus_w.key_clear = 1'b1;
    stepCycles(1);
    bus_w.key_clear = 1'b0;
    bus_w.key_valid = 1'b1;
    bus_w.key_data  = 16'h0000;
    stepCycles(1);
    bus_w.key_valid = 1'b0;
    checkOutput("w_zero_key_armed", {63'h0, bus_w.armed}, 64'h1);
    applyWideStimulus(48'h1234_5678_9ABC, 48'h1234_5678_6A4C);
    applyWideStimulus(48'hA5A5_0000_0000, 48'hA5A5_0000_F0F0);
    bus_w.in_valid = 1'b0;
    stepCycles(2);

    // Reset mid-stream clears outputs asynchronously.
    bus_w.out_ready = 1'b0;
    applyWideStimulus(48'h0000_0000_FFFF, 48'h0000_0000_0F0F);
    bus_w.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("w_held_valid", {63'h0, bus_w.out_valid}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("w_async_out_valid", {63'h0, bus_w.out_valid}, 64'h0);
    checkOutput("w_async_armed", {63'h0, bus_w.armed}, 64'h0);
    checkOutput("w_async_key_ready", {63'h0, bus_w.key_ready}, 64'h0);
    checkOutput("w_async_in_ready", {63'h0, bus_w.in_ready}, 64'h0);
    checkOutput("w_async_out_data", {16'h0, bus_w.out_data}, 64'h0);
    exp_w_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus_w.out_ready = 1'b1;
    stepCycles(1);
    checkOutput("w_post_reset_key_ready", {63'h0, bus_w.key_ready}, 64'h1);
    checkOutput("w_post_reset_armed", {63'h0, bus_w.armed}, 64'h0);
    checkOutput("drain_w", 64'(exp_w_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
